// File: rtl/isdu_pkg.sv
// Shared state encoding, opcode values and datapath mux-select codes for the
// SLC-3 instruction sequence/decode unit.
package isdu_pkg;

  typedef enum logic [4:0] {
    S_HALTED, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
    S_ADD, S_AND, S_NOT, S_BR, S_BR_TAKE, S_JMP, S_JSR, S_JSR2,
    S_LDR1, S_LDR2, S_LDR3, S_STR1, S_STR2, S_STR3,
    S_PAUSE1, S_PAUSE2
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] PCMUX_BUS  = 2'd0;
  localparam logic [1:0] PCMUX_ADDR = 2'd1;
  localparam logic [1:0] PCMUX_INC  = 2'd2;

  localparam logic [1:0] ADDR2MUX_OFF11 = 2'd0;
  localparam logic [1:0] ADDR2MUX_OFF9  = 2'd1;
  localparam logic [1:0] ADDR2MUX_OFF6  = 2'd2;
  localparam logic [1:0] ADDR2MUX_ZERO  = 2'd3;

  localparam logic [1:0] ALUK_ADD   = 2'd0;
  localparam logic [1:0] ALUK_AND   = 2'd1;
  localparam logic [1:0] ALUK_NOT   = 2'd2;
  localparam logic [1:0] ALUK_PASSA = 2'd3;

endpackage

// File: rtl/isdu_wait_counter.sv
// Memory wait-state counter: reloads while the FSM is outside a wait state and
// counts down inside one; done marks the final cycle of the wait.
module isdu_wait_counter #(
  parameter int MEM_WAIT = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic load,
  input  logic en,
  output logic done
);

  logic [3:0] count_reg, count_next;

  always_comb begin
    count_next = count_reg;
    if (load)
      count_next = 4'(MEM_WAIT - 1);
    else if (en && (count_reg != 4'd0))
      count_next = count_reg - 4'd1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      count_reg <= 4'd0;
    else
      count_reg <= count_next;
  end

  assign done = (count_reg == 4'd0);

endmodule

// File: rtl/isdu_control.sv
// SLC-3 instruction sequence/decode Moore FSM driving all datapath controls.
// Build option: define ISDU_PAUSE_LED_EN to pulse LD_LED on entry to PAUSE1.
module isdu_control
  import isdu_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic [1:0] ADDR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ALUK,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       MIO_EN,
  output logic       Mem_CE,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  state_t state_reg, state_next;
  logic   in_wait;
  logic   wait_done;

  assign in_wait = (state_reg == S_FETCH2) || (state_reg == S_LDR2) ||
                   (state_reg == S_STR3);

  isdu_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .Clk   (Clk),
    .Reset (Reset),
    .load  (!in_wait),
    .en    (in_wait),
    .done  (wait_done)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      state_reg <= S_HALTED;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_HALTED:  if (Run) state_next = S_FETCH1;
      S_FETCH1:  state_next = S_FETCH2;
      S_FETCH2:  if (wait_done) state_next = S_FETCH3;
      S_FETCH3:  state_next = S_DECODE;
      S_DECODE: begin
        unique case (Opcode)
          OP_ADD:   state_next = S_ADD;
          OP_AND:   state_next = S_AND;
          OP_NOT:   state_next = S_NOT;
          OP_BR:    state_next = S_BR;
          OP_JMP:   state_next = S_JMP;
          OP_JSR:   state_next = S_JSR;
          OP_LDR:   state_next = S_LDR1;
          OP_STR:   state_next = S_STR1;
          OP_PAUSE: state_next = S_PAUSE1;
          default:  state_next = S_FETCH1;
        endcase
      end
      S_BR:      state_next = BEN ? S_BR_TAKE : S_FETCH1;
      S_JSR:     state_next = S_JSR2;
      S_LDR1:    state_next = S_LDR2;
      S_LDR2:    if (wait_done) state_next = S_LDR3;
      S_STR1:    state_next = S_STR2;
      S_STR2:    state_next = S_STR3;
      S_STR3:    if (wait_done) state_next = S_FETCH1;
      S_PAUSE1:  if (Continue) state_next = S_PAUSE2;
      S_PAUSE2:  if (!Continue) state_next = S_FETCH1;
      default:   state_next = S_FETCH1;
    endcase
  end

  always_comb begin
    LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
    LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0;
    GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
    PCMUX = PCMUX_BUS; ADDR2MUX = ADDR2MUX_OFF11; ADDR1MUX = 1'b0;
    ALUK = ALUK_ADD; DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0;
    MIO_EN = 1'b0; Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;
    unique case (state_reg)
      S_FETCH1: begin
        GatePC = 1'b1; LD_MAR = 1'b1; PCMUX = PCMUX_INC; LD_PC = 1'b1;
      end
      S_FETCH2, S_LDR2: begin
        Mem_CE = 1'b0; Mem_OE = 1'b0; MIO_EN = 1'b1; LD_MDR = wait_done;
      end
      S_FETCH3: begin GateMDR = 1'b1; LD_IR = 1'b1; end
      S_DECODE: LD_BEN = 1'b1;
      S_ADD, S_AND: begin
        SR1MUX = 1'b1; SR2MUX = ~IR_5;
        ALUK = (state_reg == S_AND) ? ALUK_AND : ALUK_ADD;
        GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
      end
      S_NOT: begin
        SR1MUX = 1'b1; ALUK = ALUK_NOT; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
      end
      S_BR_TAKE: begin
        ADDR1MUX = 1'b1; ADDR2MUX = ADDR2MUX_OFF9; PCMUX = PCMUX_ADDR; LD_PC = 1'b1;
      end
      S_JMP: begin
        SR1MUX = 1'b1; ADDR2MUX = ADDR2MUX_ZERO; PCMUX = PCMUX_ADDR; LD_PC = 1'b1;
      end
      S_JSR: begin GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; end
      S_JSR2: begin
        PCMUX = PCMUX_ADDR; LD_PC = 1'b1;
        // JSR: PC-relative offset11; JSRR: base register with zero offset.
        if (IR_11) begin
          ADDR1MUX = 1'b1; ADDR2MUX = ADDR2MUX_OFF11;
        end else begin
          SR1MUX = 1'b1; ADDR2MUX = ADDR2MUX_ZERO;
        end
      end
      S_LDR1, S_STR1: begin
        SR1MUX = 1'b1; ADDR2MUX = ADDR2MUX_OFF6; GateMARMUX = 1'b1; LD_MAR = 1'b1;
      end
      S_LDR3: begin GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
      S_STR2: begin
        ALUK = ALUK_PASSA; GateALU = 1'b1; LD_MDR = 1'b1;
      end
      S_STR3: begin Mem_CE = 1'b0; Mem_WE = 1'b0; end
      default: ;
    endcase
  end

`ifdef ISDU_PAUSE_LED_EN
  logic led_pend_reg;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      led_pend_reg <= 1'b0;
    else
      led_pend_reg <= (state_next == S_PAUSE1) && (state_reg != S_PAUSE1);
  end

  assign LD_LED = (state_reg == S_PAUSE1) && led_pend_reg;
`else
  assign LD_LED = 1'b0;
`endif

endmodule
